// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction-fetch sequencer
// Requests a word at the PC, holds it for decode, and loads the next PC on retire.
module pc_fetch_unit #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_pc_next,
   input  logic             i_pc_we,
   input  logic             i_halt,
   input  logic [WIDTH-1:0] i_imem_data,
   input  logic             i_imem_valid,
   input  logic             i_instr_ready,
   output logic [WIDTH-1:0] o_pc,
   output logic [WIDTH-1:0] o_imem_addr,
   output logic             o_imem_rd_en,
   output logic [WIDTH-1:0] o_instr_out,
   output logic             o_instr_valid,
   output logic             o_instr_taken,
   output logic             o_halted,
   output logic [WIDTH-1:0] o_retire_cnt
);

   typedef enum logic [2:0] {
      S_REQ  = 3'd0,
      S_WAIT = 3'd1,
      S_HOLD = 3'd2,
      S_EXEC = 3'd3,
      S_HALT = 3'd4
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_instr;
   logic             r_instr_valid;
   logic             r_instr_taken;
   logic             r_halted;
   logic [WIDTH-1:0] r_retire_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_instr_taken <= 1'b0;
         r_halted      <= 1'b0;
         r_retire_cnt  <= '0;
      end else begin
         case (r_state)
            S_REQ: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_imem_valid) begin
                  r_instr       <= i_imem_data;
                  r_instr_valid <= 1'b1;
                  r_state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_instr_valid && i_instr_ready) begin
                  r_instr_valid <= 1'b0;
                  r_instr_taken <= 1'b1;
                  r_state       <= S_EXEC;
               end
            end
            S_EXEC: begin
               // pc_next is already the fully computed target; no increment here.
               if (i_pc_we) begin
                  r_pc          <= i_pc_next;
                  r_retire_cnt  <= r_retire_cnt + WIDTH'(1);
                  r_instr_taken <= 1'b0;
                  if (i_halt) begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALT;
                  end else begin
                     r_state  <= S_REQ;
                  end
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_REQ;
            end
         endcase
      end
   end

   // Read request is gated by reset so it drops the instant reset asserts.
   assign o_imem_rd_en  = (r_state == S_REQ) && !i_rst;
   assign o_pc          = r_pc;
   assign o_imem_addr   = r_pc;
   assign o_instr_out   = r_instr;
   assign o_instr_valid = r_instr_valid;
   assign o_instr_taken = r_instr_taken;
   assign o_halted      = r_halted;
   assign o_retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
// Transaction-level model: each fetch is driven as one transaction and the PC/count tracked arithmetically.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc_next;
   logic        pc_we;
   logic        halt;
   logic [15:0] imem_data;
   logic        imem_valid;
   logic        instr_ready;
   logic [15:0] pc, imem_addr, instr_out, retire_cnt;
   logic        imem_rd_en, instr_valid, instr_taken, halted;

   logic        rst4;
   logic [3:0]  w4_pc_next   = 4'hF;
   logic [3:0]  w4_imem_data = 4'h7;
   logic        w4_one       = 1'b1;
   logic        w4_zero      = 1'b0;
   logic [3:0]  w4_pc, w4_addr, w4_instr, w4_cnt;
   logic        w4_rd_en, w4_valid, w4_taken, w4_halted;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] m_pc;
   logic [15:0] m_cnt;

   typedef struct {
      logic [15:0] data;
      int          lat;
      int          rdy;
      logic [15:0] nxt;
      bit          stray;
      logic [15:0] exp_pc;
      int          exp_cnt;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
      .i_clk(clk), .i_rst(rst), .i_pc_next(pc_next), .i_pc_we(pc_we), .i_halt(halt),
      .i_imem_data(imem_data), .i_imem_valid(imem_valid), .i_instr_ready(instr_ready),
      .o_pc(pc), .o_imem_addr(imem_addr), .o_imem_rd_en(imem_rd_en), .o_instr_out(instr_out),
      .o_instr_valid(instr_valid), .o_instr_taken(instr_taken), .o_halted(halted),
      .o_retire_cnt(retire_cnt)
   );

   // Narrow instance lets the counter wrap within a short run.
   pc_fetch_unit #(.WIDTH(4), .RESET_PC(4'h0)) dut_w4 (
      .i_clk(clk), .i_rst(rst4), .i_pc_next(w4_pc_next), .i_pc_we(w4_one), .i_halt(w4_zero),
      .i_imem_data(w4_imem_data), .i_imem_valid(w4_one), .i_instr_ready(w4_one),
      .o_pc(w4_pc), .o_imem_addr(w4_addr), .o_imem_rd_en(w4_rd_en), .o_instr_out(w4_instr),
      .o_instr_valid(w4_valid), .o_instr_taken(w4_taken), .o_halted(w4_halted),
      .o_retire_cnt(w4_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Entered just after a negedge with the DUT in its request cycle; leaves just after the retire.
   task automatic do_fetch(input logic [15:0] data, input int lat, input int rdy, input int ex,
                           input logic [15:0] nxt, input bit stray, input bit hlt);
      #1;
      chk("req_rd_en", 32'(imem_rd_en), 32'd1);
      chk("req_addr", 32'(imem_addr), 32'(m_pc));
      chk("req_pc", 32'(pc), 32'(m_pc));
      imem_valid = 1'($urandom_range(0, 1));
      imem_data  = ~data;
      pc_we      = stray;
      pc_next    = 16'($urandom);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         chk("wait_rd_en", 32'(imem_rd_en), 32'd0);
         chk("wait_valid", 32'(instr_valid), 32'd0);
         chk("wait_pc", 32'(pc), 32'(m_pc));
         if (k == lat) begin
            imem_valid = 1'b1;
            imem_data  = data;
         end else begin
            imem_valid = 1'b0;
            pc_next    = 16'($urandom);
         end
      end
      @(negedge clk);
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
      for (int k = 0; k < rdy; k++) begin
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_data", 32'(instr_out), 32'(data));
         chk("hold_rd_en", 32'(imem_rd_en), 32'd0);
         instr_ready = 1'b0;
         @(negedge clk);
      end
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_data", 32'(instr_out), 32'(data));
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      pc_we       = 1'b0;
      chk("exec_taken", 32'(instr_taken), 32'd1);
      chk("exec_valid", 32'(instr_valid), 32'd0);
      chk("exec_pc", 32'(pc), 32'(m_pc));
      chk("exec_rd_en", 32'(imem_rd_en), 32'd0);
      for (int k = 0; k < ex; k++) begin
         halt = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("exec_wait_pc", 32'(pc), 32'(m_pc));
         chk("exec_wait_taken", 32'(instr_taken), 32'd1);
      end
      pc_we   = 1'b1;
      pc_next = nxt;
      halt    = hlt;
      @(negedge clk);
      pc_we = 1'b0;
      halt  = 1'b0;
      m_pc  = nxt;
      m_cnt = m_cnt + 16'd1;
      chk("ret_pc", 32'(pc), 32'(m_pc));
      chk("ret_cnt", 32'(retire_cnt), 32'(m_cnt));
      chk("ret_taken", 32'(instr_taken), 32'd0);
      chk("ret_halted", 32'(halted), 32'(hlt));
   endtask

   initial begin
      tbl[0] = '{16'hABCD, 1, 0, 16'h0001, 1'b0, 16'h0001, 1};
      tbl[1] = '{16'h1111, 5, 3, 16'h0010, 1'b0, 16'h0010, 2};
      tbl[2] = '{16'h2222, 3, 1, 16'h000B, 1'b1, 16'h000B, 3};
      tbl[3] = '{16'h3333, 2, 2, 16'hFFFF, 1'b1, 16'hFFFF, 4};
      tbl[4] = '{16'h0000, 1, 0, 16'h1234, 1'b0, 16'h1234, 5};
      tbl[5] = '{16'hFFFF, 4, 0, 16'h0000, 1'b1, 16'h0000, 6};

      rst = 1'b1; rst4 = 1'b1;
      pc_next = '0; pc_we = 1'b0; halt = 1'b0;
      imem_data = '0; imem_valid = 1'b0; instr_ready = 1'b0;
      m_pc = 16'h0000; m_cnt = 16'd0;
      #12;
      chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr_out), 32'h0);
      chk("rst_cnt", 32'(retire_cnt), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_fetch(tbl[i].data, tbl[i].lat, tbl[i].rdy, i % 3, tbl[i].nxt, tbl[i].stray, 1'b0);
         chk("tbl_pc", 32'(pc), 32'(tbl[i].exp_pc));
         chk("tbl_cnt", 32'(retire_cnt), 32'(tbl[i].exp_cnt));
      end

      do_fetch(16'h4444, 1, 0, 0, 16'h0777, 1'b0, 1'b0);
      #1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      m_pc = 16'h0000; m_cnt = 16'd0;
      chk("async_rd_en", 32'(imem_rd_en), 32'd0);
      chk("async_pc", 32'(pc), 32'h0);
      chk("async_cnt", 32'(retire_cnt), 32'd0);
      chk("async_instr", 32'(instr_out), 32'h0);
      chk("async_taken", 32'(instr_taken), 32'd0);
      @(negedge clk);
      rst        = 1'b0;
      imem_valid = 1'b1;
      imem_data  = 16'h5A5A;
      @(negedge clk);
      chk("stray_valid", 32'(instr_valid), 32'd0);
      chk("stray_instr", 32'(instr_out), 32'h0);
      imem_valid = 1'b0;
      rst = 1'b1;
      #1;
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         do_fetch(16'($urandom), $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                  16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end

      do_fetch(16'hDEAD, 2, 1, 1, 16'h0042, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         pc_we       = 1'b1;
         pc_next     = 16'($urandom);
         imem_valid  = 1'b1;
         instr_ready = 1'b1;
         @(negedge clk);
         chk("halt_rd_en", 32'(imem_rd_en), 32'd0);
         chk("halt_pc", 32'(pc), 32'(m_pc));
         chk("halt_cnt", 32'(retire_cnt), 32'(m_cnt));
         chk("halt_flag", 32'(halted), 32'd1);
      end
      pc_we = 1'b0; imem_valid = 1'b0; instr_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("recover_pc", 32'(pc), 32'h0);
      chk("recover_halted", 32'(halted), 32'd0);
      m_pc = 16'h0000; m_cnt = 16'd0;
      rst = 1'b0;
      do_fetch(16'hBEEF, 1, 0, 0, 16'h0002, 1'b0, 1'b0);

      @(negedge clk);
      rst4 = 1'b0;
      repeat (60) @(negedge clk);
      chk("w4_cnt_max", 32'(w4_cnt), 32'd15);
      chk("w4_pc", 32'(w4_pc), 32'hF);
      repeat (4) @(negedge clk);
      chk("w4_cnt_wrap", 32'(w4_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
